fifo2gmii24: RTL and testbench

Transmit-side counterpart of the HDMI-over-Ethernet video path. It takes one line-segment descriptor and 640 16-bit YUV words from a line FIFO. It emits one complete Ethernet II / IPv4 / UDP frame on a GMII transmit interface at 125 MHz. Frames use the video payload layout: packet-info byte 0x00, then y/x info, then pixel bytes. The block fills the IPv4 identification and header checksum per frame, and appends the Ethernet FCS.

---
 rtl/fifo2gmii24.sv | 189 ++++++++++++++++++
 tb/tb_fifo2gmii24.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2gmii24.sv
// Line-FIFO to GMII transmitter: wraps one line descriptor and 640 YUV words into a single
// Ethernet II / IPv4 / UDP video frame with per-frame IPv4 id/checksum and trailing FCS.
module fifo2gmii24 #(
  parameter logic [47:0] eth_dst_mac = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] eth_src_mac = 48'h0200_0000_0001,
  parameter logic [31:0] ipv4_src_tx = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [31:0] ipv4_dst_tx = {8'd192, 8'd168, 8'd0, 8'd1},
  parameter logic [15:0] src_port_tx = 16'd12345,
  parameter logic [15:0] dst_port_tx = 16'd12345,
  parameter int unsigned ifg_bytes   = 12
) (
  input  logic        clk125,
  input  logic        sys_rst_n,
  input  logic        id,
  input  logic        req,
  input  logic [11:0] y_info,
  input  logic [3:0]  x_info,
  output logic        ack,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        underrun
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StHdr  = 3'd2;
  localparam logic [2:0] StPay  = 3'd3;
  localparam logic [2:0] StFcs  = 3'd4;
  localparam logic [2:0] StIfg  = 3'd5;

  localparam logic [10:0] BcPreLast  = 11'h007;
  localparam logic [10:0] BcHdrLast  = 11'h034;
  localparam logic [10:0] BcPayLast  = 11'h534;
  localparam logic [10:0] BcFcsLast  = 11'h538;
  localparam logic [10:0] BcRdFirst  = 11'h032;
  localparam logic [10:0] BcRdLast   = 11'h530;
  localparam logic [10:0] BcCapFirst = 11'h034;
  localparam logic [10:0] BcCapLast  = 11'h532;
  localparam logic [7:0]  IfgLast    = 8'(ifg_bytes);

  logic [2:0]   state_q, state_d;
  logic [10:0]  bc_q;
  logic [7:0]   ifg_cnt_q;
  logic [11:0]  y_q;
  logic [3:0]   x_q;
  logic         id_q;
  logic [15:0]  ip_id_q;
  logic [15:0]  csum_q;
  logic [31:0]  crc_q;
  logic [15:0]  word_q;
  logic         und_q;
  logic         ack_q, rd_en_q, underrun_q, tx_en_q;
  logic [7:0]   txd_q;

  logic         tx_on, rd_slot, cap_slot;
  logic [31:0]  dst_ip;
  logic [19:0]  csum_sum;
  logic [16:0]  csum_fold;
  logic [15:0]  csum_d;
  logic [359:0] hdr, hdr_sh;
  logic [10:0]  hdr_idx, fcs_off;
  logic [31:0]  fcs;
  logic [7:0]   tx_byte;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    tx_on    = (state_q == StPre) || (state_q == StHdr) || (state_q == StPay) ||
               (state_q == StFcs);
    // One word decision every other byte; the first two slots fall in the header as lead-in.
    rd_slot  = ((state_q == StHdr) || (state_q == StPay)) && !bc_q[0] &&
               (bc_q >= BcRdFirst) && (bc_q <= BcRdLast);
    cap_slot = ((state_q == StHdr) || (state_q == StPay)) && !bc_q[0] &&
               (bc_q >= BcCapFirst) && (bc_q <= BcCapLast);
  end

  always_comb begin
    dst_ip    = {ipv4_dst_tx[31:8], ipv4_dst_tx[7:0] + {7'd0, id_q}};
    csum_sum  = 20'h04500 + 20'h0051F + {4'd0, ip_id_q} + 20'h04000 + 20'h04011
              + {4'd0, ipv4_src_tx[31:16]} + {4'd0, ipv4_src_tx[15:0]}
              + {4'd0, dst_ip[31:16]} + {4'd0, dst_ip[15:0]};
    csum_fold = {1'b0, csum_sum[15:0]} + {13'd0, csum_sum[19:16]};
    csum_d    = ~(csum_fold[15:0] + {15'd0, csum_fold[16]});
  end

  always_comb begin
    hdr = {eth_dst_mac, eth_src_mac, 16'h0800,
           8'h45, 8'h00, 16'h051F, ip_id_q, 16'h4000, 8'h40, 8'h11, csum_q,
           ipv4_src_tx, dst_ip,
           src_port_tx, dst_port_tx, 16'h050B, 16'h0000,
           8'h00, y_q[7:0], x_q, y_q[11:8]};
    hdr_idx = BcHdrLast - bc_q;
    hdr_sh  = hdr >> {hdr_idx[5:0], 3'b000};
    fcs_off = bc_q - BcPayLast - 11'd1;
    fcs     = ~crc_q;
    tx_byte = 8'h00;
    case (state_q)
      StPre:   tx_byte = (bc_q == BcPreLast) ? 8'hD5 : 8'h55;
      StHdr:   tx_byte = hdr_sh[7:0];
      StPay:   tx_byte = bc_q[0] ? word_q[15:8] : word_q[7:0];
      StFcs:   tx_byte = fcs[{fcs_off[1:0], 3'b000} +: 8];
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req) state_d = StPre;
      StPre:   if (bc_q == BcPreLast) state_d = StHdr;
      StHdr:   if (bc_q == BcHdrLast) state_d = StPay;
      StPay:   if (bc_q == BcPayLast) state_d = StFcs;
      StFcs:   if (bc_q == BcFcsLast) state_d = StIfg;
      StIfg:   if (ifg_cnt_q == IfgLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      bc_q       <= '0;
      ifg_cnt_q  <= '0;
      y_q        <= '0;
      x_q        <= '0;
      id_q       <= 1'b0;
      ip_id_q    <= '0;
      csum_q     <= '0;
      crc_q      <= '1;
      word_q     <= '0;
      und_q      <= 1'b0;
      ack_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      underrun_q <= 1'b0;
      tx_en_q    <= 1'b0;
      txd_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      underrun_q <= 1'b0;
      tx_en_q    <= tx_on;
      txd_q      <= tx_on ? tx_byte : 8'h00;
      if (tx_on) bc_q <= bc_q + 11'd1;
      if ((state_q == StIdle) && req) begin
        ack_q <= 1'b1;
        y_q   <= y_info;
        x_q   <= x_info;
        id_q  <= id;
        bc_q  <= '0;
      end
      // Latched descriptor is stable through the preamble, so the checksum settles here.
      if (state_q == StPre) begin
        crc_q  <= '1;
        csum_q <= csum_d;
      end
      if ((state_q == StHdr) || (state_q == StPay)) crc_q <= crc32_byte(crc_q, tx_byte);
      if (rd_slot) begin
        und_q      <= fifo_empty;
        rd_en_q    <= !fifo_empty;
        underrun_q <= fifo_empty;
      end
      if (cap_slot) word_q <= und_q ? 16'h0000 : fifo_dout;
      if (state_q == StIfg) begin
        ifg_cnt_q <= ifg_cnt_q + 8'd1;
        if (ifg_cnt_q == IfgLast) ip_id_q <= ip_id_q + 16'd1;
      end else begin
        ifg_cnt_q <= '0;
      end
    end
  end

  assign ack        = ack_q;
  assign fifo_rd_en = rd_en_q;
  assign underrun   = underrun_q;
  assign tx_en      = tx_en_q;
  assign txd        = txd_q;

endmodule

// File: tb/tb_fifo2gmii24.sv
// Directed bench for fifo2gmii24: FIFO model, byte-capture monitor and hand-derived frame checks.
module tb_fifo2gmii24;

  logic        clk125 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        id = 1'b0;
  logic        req = 1'b0;
  logic [11:0] y_info = '0;
  logic [3:0]  x_info = '0;
  logic        ack;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  txd;
  logic        tx_en;
  logic        underrun;

  always #4 clk125 = ~clk125;

  fifo2gmii24 dut (
    .clk125     (clk125),
    .sys_rst_n  (sys_rst_n),
    .id         (id),
    .req        (req),
    .y_info     (y_info),
    .x_info     (x_info),
    .ack        (ack),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .txd        (txd),
    .tx_en      (tx_en),
    .underrun   (underrun)
  );

  // Standard-read FIFO: data appears the cycle after the read strobe.
  logic [15:0] fq[$];
  always @(posedge clk125) begin
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  int cyc = 0, len = 0, frames = 0, acks = 0, rd_cnt = 0, und_cnt = 0, rd_while_empty = 0;
  int ack_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic prev_en = 1'b0;
  logic [7:0] fb [0:2047];

  always @(negedge clk125) begin
    cyc <= cyc + 1;
    if (ack) begin
      acks    <= acks + 1;
      ack_cyc <= cyc + 1;
    end
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (underrun) und_cnt <= und_cnt + 1;
    if (fifo_rd_en && fifo_empty) rd_while_empty <= rd_while_empty + 1;
    if (tx_en) begin
      if (!prev_en) begin
        fb[0]    <= txd;
        len      <= 1;
        rise_cyc <= cyc + 1;
      end else begin
        if (len < 2048) fb[len] <= txd;
        len <= len + 1;
      end
    end else if (prev_en) begin
      fall_cyc <= cyc + 1;
      frames   <= frames + 1;
    end
    prev_en <= tx_en;
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk125);
    #1;
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) fq.push_back(base + 16'(k));
  endtask

  task automatic wait_ack(output int lat);
    lat = -1;
    for (int i = 1; i <= 3000; i++) begin
      tick();
      if (ack) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("ack timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frame();
    int f0;
    logic done;
    f0 = frames;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (frames != f0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("frame timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] crc_model(input int first, input int last);
    logic [31:0] c;
    logic [7:0]  d;
    c = 32'hFFFF_FFFF;
    for (int i = first; i <= last; i++) begin
      d = fb[i];
      for (int b = 0; b < 8; b++) c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check_frame(input string nm, input logic [11:0] y, input logic [3:0] x,
                             input logic idv, input logic [15:0] ipid,
                             input logic [15:0] base, input int nwords);
    int bad;
    logic [335:0] he;
    logic [19:0]  s;
    check({nm, " length"}, len, 32'd1337);
    bad = 0;
    for (int i = 0; i < 7; i++) if (fb[i] !== 8'h55) bad++;
    if (fb[7] !== 8'hD5) bad++;
    check({nm, " preamble errors"}, bad, 32'd0);
    he = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 8'h45, 8'h00, 16'h051F, ipid,
          16'h4000, 8'h40, 8'h11, 16'h0000, 32'hC0A8_0002, 24'hC0A8_00, 8'd1 + {7'd0, idv},
          16'h3039, 16'h3039, 16'h050B, 16'h0000};
    bad = 0;
    for (int i = 0; i < 42; i++) begin
      if ((8 + i) == 'h20 || (8 + i) == 'h21) continue;
      if (fb[8 + i] !== he[8 * (41 - i) +: 8]) bad++;
    end
    check({nm, " header errors"}, bad, 32'd0);
    check({nm, " ip_id"}, {16'd0, fb['h1A], fb['h1B]}, {16'd0, ipid});
    check({nm, " dst ip octet"}, {24'd0, fb['h29]}, {24'd0, 8'd1 + {7'd0, idv}});
    s = '0;
    for (int i = 0; i < 10; i++) s = s + {4'd0, fb['h16 + 2 * i], fb['h17 + 2 * i]};
    s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
    s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
    check({nm, " ip checksum verify"}, {16'd0, s[15:0]}, 32'h0000_FFFF);
    check({nm, " info bytes"}, {8'd0, fb['h32], fb['h33], fb['h34]},
          {8'd0, 8'h00, y[7:0], x, y[11:8]});
    bad = 0;
    for (int k = 0; k < 640; k++) begin
      logic [15:0] w;
      w = (k < nwords) ? base + 16'(k) : 16'h0000;
      if ({fb['h35 + 2 * k], fb['h36 + 2 * k]} !== w) bad++;
    end
    check({nm, " payload errors"}, bad, 32'd0);
    check({nm, " fcs"}, {fb['h538], fb['h537], fb['h536], fb['h535]}, crc_model(8, 'h534));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat, rd0, und0, prev_fall, bad;
    logic [11:0] ys [0:2];
    logic [3:0]  xs [0:2];
    ys[0] = 12'h0A1; ys[1] = 12'h0B2; ys[2] = 12'h0C3;
    xs[0] = 4'h1;    xs[1] = 4'h2;    xs[2] = 4'h3;
    prev_fall = 0;

    repeat (3) tick();
    check("reset outputs", {20'd0, txd, tx_en, fifo_rd_en, ack, underrun}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (4) tick();
    check("idle outputs", {20'd0, txd, tx_en, fifo_rd_en, ack, underrun}, 32'd0);

    // Three back-to-back frames, req held high, descriptor changed after each ack.
    push_words(16'h1000, 640);
    id = 1'b1;
    y_info = ys[0];
    x_info = xs[0];
    req = 1'b1;
    wait_ack(lat);
    check("ack latency", lat, 32'd1);
    for (int f = 0; f < 3; f++) begin
      if (f < 2) begin
        y_info = ys[f + 1];
        x_info = xs[f + 1];
      end else begin
        req = 1'b0;
      end
      wait_frame();
      check("tx_en rise after ack", rise_cyc - ack_cyc, 32'd1);
      if (f > 0) check("ifg at least 12", 32'(rise_cyc - prev_fall >= 12), 32'd1);
      check_frame("b2b", ys[f], xs[f], 1'b1, 16'(f), 16'h1000 * 16'(f + 1), 640);
      prev_fall = fall_cyc;
      if (f < 2) begin
        push_words(16'h1000 * 16'(f + 2), 640);
        wait_ack(lat);
        check("next ack after ifg", ack_cyc - fall_cyc, 32'd13);
      end
    end
    repeat (20) tick();
    check("ack count", acks, 32'd3);

    // Basic frame.
    push_words(16'h0000, 640);
    rd0 = rd_cnt;
    und0 = und_cnt;
    id = 1'b0;
    y_info = 12'h123;
    x_info = 4'h5;
    req = 1'b1;
    wait_ack(lat);
    req = 1'b0;
    wait_frame();
    check_frame("basic", 12'h123, 4'h5, 1'b0, 16'd3, 16'h0000, 640);
    check("basic byte 0x33/0x34", {16'd0, fb['h33], fb['h34]}, 32'h0000_2351);
    check("basic first word", {16'd0, fb['h35], fb['h36]}, 32'h0000_0000);
    check("basic last word", {16'd0, fb['h533], fb['h534]}, 32'h0000_027F);
    check("basic rd_en count", rd_cnt - rd0, 32'd640);
    check("basic underrun count", und_cnt - und0, 32'd0);

    // Underrun: only 600 words available.
    repeat (20) tick();
    push_words(16'h8000, 600);
    rd0 = rd_cnt;
    und0 = und_cnt;
    y_info = 12'h7FF;
    x_info = 4'hF;
    req = 1'b1;
    wait_ack(lat);
    req = 1'b0;
    wait_frame();
    check_frame("underrun", 12'h7FF, 4'hF, 1'b0, 16'd4, 16'h8000, 600);
    check("underrun pulses", und_cnt - und0, 32'd40);
    check("underrun rd_en count", rd_cnt - rd0, 32'd600);
    bad = 0;
    for (int i = 'h535 - 80; i < 'h535; i++) if (fb[i] !== 8'h00) bad++;
    check("underrun tail nonzero", bad, 32'd0);

    // Reset in the middle of the payload.
    repeat (20) tick();
    push_words(16'h5A00, 640);
    y_info = 12'h055;
    x_info = 4'h3;
    req = 1'b1;
    wait_ack(lat);
    req = 1'b0;
    tick();
    check("rst frame started", {31'd0, tx_en}, 32'd1);
    for (int i = 0; i < 2000 && len < 'h200; i++) tick();
    check("rst reached bc 0x200", 32'(len >= 'h200), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("async reset outputs", {20'd0, txd, tx_en, fifo_rd_en, ack, underrun}, 32'd0);
    repeat (3) tick();
    sys_rst_n = 1'b1;
    fq.delete();
    repeat (5) tick();
    push_words(16'h0100, 640);
    y_info = 12'h001;
    x_info = 4'h0;
    req = 1'b1;
    wait_ack(lat);
    req = 1'b0;
    wait_frame();
    check_frame("post reset", 12'h001, 4'h0, 1'b0, 16'd0, 16'h0100, 640);

    check("rd_en while empty", rd_while_empty, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
